// File: rtl/gpu_pkg.sv
// Shared GPU definitions: pixel formats, RGB triplet type, colour expansion and
// an elaboration-time ceil(log2) helper.
package gpu_pkg;

    typedef enum logic {
        FMT_RGB565 = 1'b0,
        FMT_RGB332 = 1'b1
    } fmt_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Replicating the top bits maps full-scale codes to 0xFF and zero to 0x00.
    function automatic rgb_t expand565(input logic [15:0] px);
        rgb_t c;
        c.r = {px[15:11], px[15:13]};
        c.g = {px[10:5], px[10:9]};
        c.b = {px[4:0], px[4:2]};
        return c;
    endfunction

    function automatic rgb_t expand332(input logic [7:0] px);
        rgb_t c;
        c.r = {px[7:5], px[7:5], px[7:6]};
        c.g = {px[4:2], px[4:2], px[4:3]};
        c.b = {4{px[1:0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster counters advancing on the pixel clock-enable, with combinational
// active/sync decode of the current position and line/frame wrap flags.
module vga_timing
    import gpu_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int H_W     = clog2(H_TOTAL),
    localparam int V_W     = clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_ce,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           active,
    output logic           hs,
    output logic           vs,
    output logic           line_end,
    output logic           frame_wrap
);

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int VS_START = V_ACTIVE + V_FP;

    logic in_hs;
    logic in_vs;
    logic last_line;

    assign line_end   = (int'(x) == H_TOTAL - 1);
    assign last_line  = (int'(y) == V_TOTAL - 1);
    assign frame_wrap = pix_ce && line_end && last_line;

    assign active = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
    assign in_hs  = (int'(x) >= HS_START) && (int'(x) < HS_START + H_SYNC);
    assign in_vs  = (int'(y) >= VS_START) && (int'(y) < VS_START + V_SYNC);
    assign hs     = in_hs ? SYNC_POL : !SYNC_POL;
    assign vs     = in_vs ? SYNC_POL : !SYNC_POL;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (pix_ce) begin
            if (line_end) begin
                x <= '0;
                y <= last_line ? '0 : y + V_W'(1);
            end else begin
                x <= x + H_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: shadowed base/format, scaled address generation, a
// three-stage pix_ce pipeline to the DAC pins, and RGB565/RGB332 expansion.
module fb_scanout
    import gpu_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 2,
    parameter int ADDR_W   = 17,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_ce,
    input  logic              enable,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic              bpp8,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_rd,
    input  logic [15:0]       vram_data,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_W     = clog2(H_TOTAL);
    localparam int V_W     = clog2(V_TOTAL);
    localparam int SHIFT   = clog2(SCALE);
    localparam int FB_W    = H_ACTIVE / SCALE;

    typedef struct packed {
        logic valid;
        logic de;
        logic hs;
        logic vs;
        logic sel;
        fmt_t fmt;
    } pipe_t;

    localparam pipe_t PIPE_RST = '{valid: 1'b0, de: 1'b0, hs: !SYNC_POL,
                                   vs: !SYNC_POL, sel: 1'b0, fmt: FMT_RGB565};

    logic [H_W-1:0]    x;
    logic [V_W-1:0]    y;
    logic              active;
    logic              hs;
    logic              vs;
    logic              line_end;
    logic              frame_wrap;

    logic [ADDR_W-1:0] base_q;
    fmt_t              fmt_q;
    logic [ADDR_W-1:0] row_idx;
    logic [ADDR_W-1:0] pix;
    logic [ADDR_W-1:0] word_off;
    logic              row_done;

    pipe_t             s1;
    pipe_t             s2;
    logic [15:0]       data2;
    rgb_t              pix_rgb;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_ce     (pix_ce),
        .x          (x),
        .y          (y),
        .active     (active),
        .hs         (hs),
        .vs         (vs),
        .line_end   (line_end),
        .frame_wrap (frame_wrap)
    );

    // Framebuffer rows advance once every SCALE screen lines; the stride is an
    // accumulated add, so no multiplier sits on the address path.
    assign row_done = ((int'(y) + 1) % SCALE) == 0;
    assign pix      = row_idx + ADDR_W'(x >> SHIFT);
    assign word_off = (fmt_q == FMT_RGB332) ? (pix >> 1) : pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            fmt_q       <= FMT_RGB565;
            row_idx     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                base_q  <= fb_base;
                fmt_q   <= bpp8 ? FMT_RGB332 : FMT_RGB565;
                row_idx <= '0;
            end else if (pix_ce && line_end && int'(y) < V_ACTIVE && row_done) begin
                row_idx <= row_idx + ADDR_W'(FB_W);
            end
        end
    end

    // S1: address issue. vram_rd is refreshed every clk so it is a single-clk strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_addr <= '0;
            vram_rd   <= 1'b0;
            s1        <= PIPE_RST;
        end else begin
            vram_rd <= pix_ce && active && enable;
            if (pix_ce) begin
                vram_addr <= base_q + word_off;
                s1        <= '{valid: active && enable, de: active, hs: hs,
                               vs: vs, sel: pix[0], fmt: fmt_q};
            end
        end
    end

    // S2: read data has landed by the next pix_ce, since ticks are >= 2 clk apart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2    <= PIPE_RST;
            data2 <= '0;
        end else if (pix_ce) begin
            s2    <= s1;
            data2 <= vram_data;
        end
    end

    // NOTE: pix_rgb gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pix_rgb = '0;
        if (s2.valid) begin
            if (s2.fmt == FMT_RGB332) pix_rgb = expand332(s2.sel ? data2[15:8] : data2[7:0]);
            else                      pix_rgb = expand565(data2);
        end
    end

    // S3: output registers; sync and DE share the colour's latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_de <= 1'b0;
            vga_hs <= !SYNC_POL;
            vga_vs <= !SYNC_POL;
        end else if (pix_ce) begin
            vga_r  <= pix_rgb.r;
            vga_g  <= pix_rgb.g;
            vga_b  <= pix_rgb.b;
            vga_de <= s2.de;
            vga_hs <= s2.hs;
            vga_vs <= s2.vs;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a reduced 24x12 raster (16x8 active, SCALE 2)
// with pix_ce at clk/2 and VRAM data driven directly by the bench.
module tb_fb_scanout;

    localparam int FRAME_TICKS = 24 * 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_ce;
    logic        enable;
    logic [16:0] fb_base;
    logic        bpp8;
    logic [16:0] vram_addr;
    logic        vram_rd;
    logic [15:0] vram_data;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    int          hs_lo;
    int          vs_lo;
    int          de_hi;
    int          fs_ticks;
    int          errs;
    logic        fs_end;
    logic        de_t2;
    logic        de_t3;
    logic        rd_at5;
    logic        rd_after5;
    logic [23:0] px [4];
    logic [16:0] rd_q [$];

    fb_scanout #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SCALE    (2),  .ADDR_W (17), .SYNC_POL (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_ce      (pix_ce),
        .enable      (enable),
        .fb_base     (fb_base),
        .bpp8        (bpp8),
        .vram_addr   (vram_addr),
        .vram_rd     (vram_rd),
        .vram_data   (vram_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        pix_ce = 1'b0;
        forever @(negedge clk) pix_ce = ~pix_ce;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_tick();
        do @(posedge clk); while (!pix_ce);
        @(negedge clk);
    endtask

    task automatic wait_fs(output int ticks);
        ticks = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (pix_ce) ticks++;
            @(negedge clk);
            if (frame_start) return;
        end
        ticks = -1;
    endtask

    function automatic logic [16:0] exp_addr(input logic [16:0] base, input bit is8, input int k);
        int yy  = k / 16;
        int xx  = k % 16;
        int pxi = (yy / 2) * 8 + xx / 2;
        if (is8) pxi = pxi >> 1;
        return base + 17'(pxi);
    endfunction

    // Runs one frame starting with S0 at (0,0). Position p is output on tick p+3;
    // its data must be on vram_data before tick p+2.
    task automatic run_frame(input int chg_t, input logic [16:0] chg_base,
                             input logic chg_bpp8, input logic [63:0] data4);
        rd_q.delete();
        hs_lo = 0;
        vs_lo = 0;
        de_hi = 0;
        for (int t = 1; t <= FRAME_TICKS; t++) begin
            next_tick();
            if (vram_rd) rd_q.push_back(vram_addr);
            if (!vga_hs) hs_lo++;
            if (!vga_vs) vs_lo++;
            if (vga_de)  de_hi++;
            if (t == 2) de_t2 = vga_de;
            if (t == 3) de_t3 = vga_de;
            if (t >= 3 && t <= 6) px[t-3] = {vga_r, vga_g, vga_b};
            if (t >= 1 && t <= 4) vram_data = data4[16*(t-1) +: 16];
            if (t == chg_t) begin
                fb_base = chg_base;
                bpp8    = chg_bpp8;
            end
            if (t == 5) begin
                rd_at5 = vram_rd;
                @(negedge clk);
                rd_after5 = vram_rd;
            end
        end
        fs_end = frame_start;
    endtask

    task automatic check_addrs(input string tag, input logic [16:0] base, input bit is8);
        errs = 0;
        for (int k = 0; k < rd_q.size() && k < 128; k++)
            if (rd_q[k] !== exp_addr(base, is8, k)) errs++;
        check(tag, errs, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        fb_base   = 17'h0;
        bpp8      = 1'b0;
        vram_data = 16'hF800;

        // Reset values while pix_ce is toggling
        repeat (4) @(negedge clk);
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_de", vga_de, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_addr", vram_addr, 0);
        check("rst_rd", vram_rd, 0);
        check("rst_fs", frame_start, 0);

        // Run into line 1, then reset mid-stream
        rst_n = 1'b1;
        repeat (30) next_tick();
        check("pre_rst_de", vga_de, 1);
        check("pre_rst_rgb", {vga_r, vga_g, vga_b}, 24'hFF0000);
        check("pre_rst_rd", vram_rd, 1);
        check("pre_rst_addr", vram_addr, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd", vram_rd, 0);
        check("mid_rst_addr", vram_addr, 0);
        check("mid_rst_de", vga_de, 0);
        check("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_fs(fs_ticks);
        check("first_fs_ticks", fs_ticks, FRAME_TICKS);
        @(negedge clk);
        check("fs_one_clk", frame_start, 0);

        // Frame A: 16 bpp, base 0, colour vectors; base switches to 0x8000 mid-frame
        run_frame(100, 17'h08000, 1'b0, {16'h8410, 16'h001F, 16'h07E0, 16'hF800});
        check("A_fs_period", fs_end, 1);
        check("A_hs_lo", hs_lo, 3 * 12);
        check("A_vs_lo", vs_lo, 2 * 24);
        check("A_de_hi", de_hi, 16 * 8);
        check("A_latency_de2", de_t2, 0);
        check("A_latency_de3", de_t3, 1);
        check("A_565_red", px[0], 24'hFF0000);
        check("A_565_green", px[1], 24'h00FF00);
        check("A_565_blue", px[2], 24'h0000FF);
        check("A_565_mid", px[3], 24'h848284);
        check("A_rd_pulse", rd_at5, 1);
        check("A_rd_one_clk", rd_after5, 0);
        check("A_rd_count", rd_q.size(), 128);
        if (rd_q.size() == 128) begin
            check("A_l0_p1", rd_q[1], 0);
            check("A_l0_p2", rd_q[2], 1);
            check("A_l0_p15", rd_q[15], 7);
            check("A_l1_start", rd_q[16], 0);
            check("A_l2_start", rd_q[32], 8);
            check("A_last_start", rd_q[112], 24);
            check("A_last_addr", rd_q[127], 31);
        end
        check_addrs("A_addr_seq", 17'h0, 1'b0);

        // Frame B: new base applies; bpp8/base change mid-frame is shadowed
        run_frame(100, 17'h00100, 1'b1, {4{16'hE01C}});
        check("B_fs_period", fs_end, 1);
        check("B_rd_count", rd_q.size(), 128);
        if (rd_q.size() == 128) begin
            check("B_first_addr", rd_q[0], 17'h08000);
            check("B_last_addr", rd_q[127], 17'h0801F);
        end
        check_addrs("B_addr_seq", 17'h08000, 1'b0);
        check("B_565_e01c", px[0], 24'hE700E7);

        // Frame C: RGB332, base 0x100, word 0xE01C
        run_frame(0, 17'h0, 1'b0, {4{16'hE01C}});
        check("C_rd_count", rd_q.size(), 128);
        if (rd_q.size() == 128) begin
            check("C_pix0_addr", rd_q[0], 17'h00100);
            check("C_pix1_addr", rd_q[2], 17'h00100);
            check("C_pix1b_addr", rd_q[3], 17'h00100);
            check("C_pix2_addr", rd_q[4], 17'h00101);
            check("C_last_addr", rd_q[127], 17'h0010F);
        end
        check_addrs("C_addr_seq", 17'h00100, 1'b1);
        check("C_332_low", px[0], 24'h00FF00);
        check("C_332_high", px[2], 24'hFF0000);

        // Frame D: scan-out disabled, syncs keep running
        enable = 1'b0;
        run_frame(0, 17'h0, 1'b0, {4{16'hF800}});
        check("D_fs_period", fs_end, 1);
        check("D_rd_count", rd_q.size(), 0);
        check("D_black0", px[0], 0);
        check("D_black2", px[2], 0);
        check("D_hs_lo", hs_lo, 3 * 12);
        check("D_vs_lo", vs_lo, 2 * 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
